// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the single-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

   localparam int DEF_N_REQ  = 3;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 4;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
   parameter int N_REQ = 3,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] win,
   output logic [PTR_W-1:0] win_idx,
   output logic             valid
);

   int               j;
   logic [PTR_W-1:0] jj;

   always_comb begin
      win     = '0;
      win_idx = '0;
      valid   = 1'b0;
      j       = 0;
      jj      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         jj = PTR_W'(j);
         if (!valid && req[jj]) begin
            valid   = 1'b1;
            win[jj] = 1'b1;
            win_idx = jj;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner arbiter for one synchronous RAM port with a forced idle GAP between owners.
// Optional per-requester grant counters: define MEM_ARB_STATS_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_wren,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_data,
   output logic                      mem_wren,
   input  logic [DATA_W-1:0]         mem_q
`ifdef MEM_ARB_STATS_EN
   ,output logic [N_REQ*8-1:0]       grant_cnt
`endif
);

   localparam int PTR_W = ptr_width(N_REQ);

   arb_state_e       state_q, state_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] rv_q, rv_d;

   logic [N_REQ-1:0] pick_win;
   logic [PTR_W-1:0] pick_idx;
   logic             pick_vld;
   logic             grant_fire;
   logic             drive;

   rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .win     (pick_win),
      .win_idx (pick_idx),
      .valid   (pick_vld)
   );

   // The port is only driven while the owner still holds req; its release cycle is dead.
   assign drive = (state_q == OWN) && req[owner_q] && !reset;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      gnt_d      = '0;
      grant_fire = 1'b0;
      case (state_q)
         IDLE, GAP: begin
            if (pick_vld) begin
               state_d    = OWN;
               owner_d    = pick_idx;
               ptr_d      = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
               gnt_d      = pick_win;
               grant_fire = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         OWN: begin
            if (req[owner_q]) gnt_d = gnt_q;
            else              state_d = GAP;
         end
         default: state_d = IDLE;
      endcase
      rv_d = (drive && !req_wren[owner_q]) ? gnt_q : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         rv_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         rv_q    <= rv_d;
      end
   end

   assign gnt      = gnt_q;
   assign mem_addr = drive ? req_addr[owner_q*ADDR_W +: ADDR_W] : '0;
   assign mem_data = drive ? req_data[owner_q*DATA_W +: DATA_W] : '0;
   assign mem_wren = drive && req_wren[owner_q];
   assign rvalid   = reset ? '0 : rv_q;
   assign rdata    = (!reset && |rv_q) ? mem_q : '0;

`ifdef MEM_ARB_STATS_EN
   logic [N_REQ-1:0][7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (grant_fire && cnt_q[pick_idx] != 8'hff)
         cnt_d[pick_idx] = cnt_q[pick_idx] + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus hand sequences for mem_port_arbiter (N_REQ=3, 4-bit addr/data).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req;
   logic [11:0] req_addr;
   logic [11:0] req_data;
   logic [2:0]  req_wren;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [3:0]  rdata;
   logic [3:0]  mem_addr;
   logic [3:0]  mem_data;
   logic        mem_wren;
   logic [3:0]  mem_q;
`ifdef MEM_ARB_STATS_EN
   logic [23:0] grant_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.N_REQ(3), .ADDR_W(4), .DATA_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_addr (req_addr),
      .req_data (req_data),
      .req_wren (req_wren),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_wren (mem_wren),
      .mem_q    (mem_q)
`ifdef MEM_ARB_STATS_EN
      ,.grant_cnt(grant_cnt)
`endif
   );

   // 16-word synchronous RAM behind the port
   logic [3:0] ram [16];
   always @(posedge clk) begin
      if (mem_wren) ram[mem_addr] <= mem_data;
      mem_q <= ram[mem_addr];
   end

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [11:0] addr;
      logic [11:0] data;
      logic [2:0]  wren;
      logic [2:0]  gnt;
      logic [2:0]  rv;
      logic [3:0]  rdata;
      logic        mwren;
      logic [3:0]  maddr;
      logic [3:0]  mdata;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic [2:0] rq, input logic [11:0] a,
                      input logic [11:0] d, input logic [2:0] w, input logic [2:0] g,
                      input logic [2:0] rv, input logic [3:0] rd, input logic mw,
                      input logic [3:0] ma, input logic [3:0] md);
      vec_t v;
      v.rst = rst; v.req = rq; v.addr = a; v.data = d; v.wren = w;
      v.gnt = g; v.rv = rv; v.rdata = rd; v.mwren = mw; v.maddr = ma; v.mdata = md;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic [2:0] rq, input logic [11:0] a,
                           input logic [11:0] d, input logic [2:0] w);
      req = rq; req_addr = a; req_data = d; req_wren = w;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_in(3'b000, 12'h0, 12'h0, 3'b000);
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive_in(3'b000, 12'h0, 12'h0, 3'b000);
      next_cycle();
      next_cycle();
      #3;
      chk("reset gnt", 32'(gnt), 0);
      chk("reset rvalid", 32'(rvalid), 0);
      chk("reset rdata", 32'(rdata), 0);
      chk("reset mem_wren", 32'(mem_wren), 0);
      chk("reset mem_addr", 32'(mem_addr), 0);
      chk("reset mem_data", 32'(mem_data), 0);
      next_cycle();

      //  rst req  addr     data     wren    gnt     rv      rd  mw ma  md
      // single owner: write 5<=9, read 5, release during the data cycle
      add(0, 3'b001, 12'h005, 12'h009, 3'b001, 3'b000, 3'b000, 0, 0, 0, 0);
      add(0, 3'b001, 12'h375, 12'h779, 3'b101, 3'b001, 3'b000, 0, 1, 5, 9);
      add(0, 3'b001, 12'h005, 12'h000, 3'b000, 3'b001, 3'b000, 0, 0, 5, 0);
      add(0, 3'b000, 12'h000, 12'h000, 3'b000, 3'b001, 3'b001, 9, 0, 0, 0);
      add(0, 3'b000, 12'h000, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
      // reset returns the pointer to 0, then three simultaneous writers
      add(1, 3'b000, 12'h000, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
      add(0, 3'b111, 12'h321, 12'h321, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
      add(0, 3'b111, 12'h321, 12'h321, 3'b111, 3'b001, 3'b000, 0, 1, 1, 1);
      add(0, 3'b111, 12'h321, 12'h321, 3'b111, 3'b001, 3'b000, 0, 1, 1, 1);
      add(0, 3'b110, 12'h321, 12'h321, 3'b111, 3'b001, 3'b000, 0, 0, 0, 0);
      add(0, 3'b110, 12'h321, 12'h321, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
      add(0, 3'b110, 12'h321, 12'h321, 3'b111, 3'b010, 3'b000, 0, 1, 2, 2);
      add(0, 3'b110, 12'h321, 12'h321, 3'b111, 3'b010, 3'b000, 0, 1, 2, 2);
      add(0, 3'b100, 12'h321, 12'h321, 3'b111, 3'b010, 3'b000, 0, 0, 0, 0);
      add(0, 3'b100, 12'h321, 12'h321, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
      add(0, 3'b100, 12'h321, 12'h321, 3'b111, 3'b100, 3'b000, 0, 1, 3, 3);
      add(0, 3'b100, 12'h321, 12'h321, 3'b111, 3'b100, 3'b000, 0, 1, 3, 3);
      add(0, 3'b000, 12'h321, 12'h321, 3'b111, 3'b100, 3'b000, 0, 0, 0, 0);
      add(0, 3'b000, 12'h000, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
      add(0, 3'b000, 12'h000, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
      // owner 1 reads then hands over while requester 0 raises req the same cycle
      add(0, 3'b010, 12'h010, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
      add(0, 3'b010, 12'h010, 12'h000, 3'b000, 3'b010, 3'b000, 0, 0, 1, 0);
      add(0, 3'b001, 12'h002, 12'h000, 3'b000, 3'b010, 3'b010, 1, 0, 0, 0);
      add(0, 3'b001, 12'h002, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
      add(0, 3'b001, 12'h002, 12'h000, 3'b000, 3'b001, 3'b000, 0, 0, 2, 0);
      add(0, 3'b000, 12'h000, 12'h000, 3'b000, 3'b001, 3'b001, 2, 0, 0, 0);
      add(0, 3'b000, 12'h000, 12'h000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         reset = tbl[i].rst;
         drive_in(tbl[i].req, tbl[i].addr, tbl[i].data, tbl[i].wren);
         #3;
         chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
         chk($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
         chk($sformatf("vec%0d rdata", i), 32'(rdata), 32'(tbl[i].rdata));
         chk($sformatf("vec%0d mem_wren", i), 32'(mem_wren), 32'(tbl[i].mwren));
         chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].maddr));
         chk($sformatf("vec%0d mem_data", i), 32'(mem_data), 32'(tbl[i].mdata));
         next_cycle();
      end

      // long ownership by requester 1 with requester 2 waiting
      do_reset();
      drive_in(3'b010, 12'h000, 12'h000, 3'b000);
      next_cycle();
      drive_in(3'b110, 12'h000, 12'h000, 3'b000);
      for (int k = 0; k < 300; k++) begin
         #3;
         chk($sformatf("hold%0d gnt", k), 32'(gnt), 32'b010);
         next_cycle();
      end
      drive_in(3'b100, 12'h000, 12'h000, 3'b000);
      #3; chk("release gnt", 32'(gnt), 32'b010);
      next_cycle();
      #3; chk("gap gnt", 32'(gnt), 32'b000);
      next_cycle();
      #3; chk("handover gnt", 32'(gnt), 32'b100);
      next_cycle();

      // reset while requester 2 has a read in flight
      do_reset();
      drive_in(3'b100, 12'h300, 12'h000, 3'b000);
      next_cycle();
      #3;
      chk("own2 gnt", 32'(gnt), 32'b100);
      chk("own2 mem_addr", 32'(mem_addr), 3);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      #3;
      chk("rst own gnt", 32'(gnt), 0);
      chk("rst own rvalid", 32'(rvalid), 0);
      chk("rst own rdata", 32'(rdata), 0);
      reset = 1'b0;
      drive_in(3'b111, 12'h000, 12'h000, 3'b000);
      next_cycle();
      #3;
      chk("post-rst winner", 32'(gnt), 32'b001);
      next_cycle();

`ifdef MEM_ARB_STATS_EN
      do_reset();
      for (int k = 0; k < 260; k++) begin
         drive_in(3'b001, 12'h000, 12'h000, 3'b000);
         next_cycle();
         drive_in(3'b000, 12'h000, 12'h000, 3'b000);
         next_cycle();
      end
      #3;
      chk("grant_cnt0 sat", 32'(grant_cnt[7:0]), 255);
      chk("grant_cnt1", 32'(grant_cnt[15:8]), 0);
      chk("grant_cnt2", 32'(grant_cnt[23:16]), 0);
      next_cycle();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
